// File: rtl/al422_frame_writer.sv
// al422_frame_writer: streams byte frames into an AL422 FIFO write port.
// al_wck toggles every in_clk cycle; one slot = low phase + high phase.
// Bytes are accepted only in the high phase, and the resulting write is
// launched at the start of the next slot.
// Build option: define AL422_WR_PAD_EN to zero-pad a short frame up to
// FRAME_BYTES before the next frame starts. Without it, a short frame is
// left truncated in the FIFO.
module al422_frame_writer #(
    parameter int FRAME_BYTES = 6144,
    parameter int WRST_CYCLES = 4
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       al_wck,
    output logic       al_we_n,
    output logic       al_wrst_n,
    output logic [7:0] al_data,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int RW = $clog2(WRST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BYTES);
    localparam logic [RW-1:0] RST_LAST = RW'(WRST_CYCLES);

`ifdef AL422_WR_PAD_EN
    typedef enum logic [1:0] {S_IDLE, S_RST, S_WRITE, S_PAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RST, S_WRITE} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    data_q, data_d;
    logic          wck_q, wck_d;
    logic          we_n_q, we_n_d;
    logic          wrst_n_q, wrst_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic slot_end;    // current cycle is the high phase; next edge starts a slot
    logic accept;
    logic sof_acc;
    logic last_write;  // the write launched now would be the frame's final byte

    assign slot_end   = wck_q;
    assign in_ready   = wck_q && (state_q == S_IDLE || state_q == S_WRITE);
    assign accept     = in_valid && in_ready;
    assign sof_acc    = accept && in_sof;
    assign last_write = (cnt_q + CW'(1)) == CNT_FULL;

    assign al_wck     = wck_q;
    assign al_we_n    = we_n_q;
    assign al_wrst_n  = wrst_n_q;
    assign al_data    = data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

    // State and datapath registers, all cleared asynchronously.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rst_cnt_q <= '0;
            hold_q    <= 8'h00;
            data_q    <= 8'h00;
            wck_q     <= 1'b0;
            we_n_q    <= 1'b1;
            wrst_n_q  <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_cnt_q <= rst_cnt_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            wck_q     <= wck_d;
            we_n_q    <= we_n_d;
            wrst_n_q  <= wrst_n_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state decision, taken only at slot boundaries.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            case (state_q)
                S_IDLE:  if (sof_acc) state_d = S_RST;
                S_RST:   if (rst_cnt_q == RST_LAST) state_d = last_write ? S_IDLE : S_WRITE;
                S_WRITE: begin
                    if (sof_acc) begin
`ifdef AL422_WR_PAD_EN
                        state_d = S_PAD;
`else
                        state_d = S_RST;
`endif
                    end else if (accept && last_write) begin
                        state_d = S_IDLE;
                    end
                end
`ifdef AL422_WR_PAD_EN
                S_PAD:   if (cnt_q == CNT_FULL) state_d = S_RST;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered-output and datapath next values for the slot being launched.
    always_comb begin
        wck_d     = ~wck_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        hold_d    = hold_q;
        data_d    = data_q;
        we_n_d    = we_n_q;
        wrst_n_d  = wrst_n_q;
        if (slot_end) begin
            // Each new slot is idle unless one of the cases below launches something.
            we_n_d   = 1'b1;
            wrst_n_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (sof_acc) begin
                        hold_d    = in_data;
                        wrst_n_d  = 1'b0;
                        rst_cnt_d = RW'(1);
                        cnt_d     = '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        data_d = hold_q;
                        we_n_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                        done_d = last_write;
                    end else begin
                        wrst_n_d  = 1'b0;
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_WRITE: begin
                    if (sof_acc) begin
                        err_d  = 1'b1;
                        hold_d = in_data;
`ifdef AL422_WR_PAD_EN
                        data_d = 8'h00;
                        we_n_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
`else
                        wrst_n_d  = 1'b0;
                        rst_cnt_d = RW'(1);
                        cnt_d     = '0;
`endif
                    end else if (accept) begin
                        data_d = in_data;
                        we_n_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                        done_d = last_write;
                    end
                end
`ifdef AL422_WR_PAD_EN
                S_PAD: begin
                    if (cnt_q == CNT_FULL) begin
                        wrst_n_d  = 1'b0;
                        rst_cnt_d = RW'(1);
                        cnt_d     = '0;
                    end else begin
                        data_d = 8'h00;
                        we_n_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Testbench for al422_frame_writer (FRAME_BYTES = 6, WRST_CYCLES = 2).
// A byte-level reference model turns every accepted byte into the AL422-side
// events it must cause (write-pointer reset, byte writes, done / err pulses).
// A monitor decodes the same events from the DUT pins and pops/compares them.
module tb_al422_frame_writer;

    localparam int FB = 6;
    localparam int WR = 2;

    localparam logic [1:0] EV_W    = 2'd0;
    localparam logic [1:0] EV_RST  = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       al_wck, al_we_n, al_wrst_n, frame_done, frame_err;
    logic [7:0] al_data;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];

    // Reference model state: inside a frame or not, and bytes already placed.
    bit  m_in_frame = 0;
    int  m_cnt = 0;

    al422_frame_writer #(.FRAME_BYTES(FB), .WRST_CYCLES(WR)) dut (
        .in_clk(in_clk), .in_nrst(in_nrst), .in_data(in_data),
        .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .al_wck(al_wck), .al_we_n(al_we_n), .al_wrst_n(al_wrst_n),
        .al_data(al_data), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push(input logic [1:0] k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void model_write(input logic [7:0] d);
        m_cnt++;
        if (m_cnt == FB) begin
            push(EV_DONE, 8'h00);
            m_in_frame = 0;
        end
        push(EV_W, d);
    endfunction

    function automatic void model_start(input logic [7:0] d);
        push(EV_RST, 8'h00);
        m_in_frame = 1;
        m_cnt = 0;
        model_write(d);
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic s);
        if (!m_in_frame) begin
            if (s) model_start(d);
        end else if (s) begin
            push(EV_ERR, 8'h00);
`ifdef AL422_WR_PAD_EN
            for (int i = m_cnt; i < FB; i++) push(EV_W, 8'h00);
`endif
            model_start(d);
        end else begin
            model_write(d);
        end
    endfunction

    // ---------------- monitor ----------------
    task automatic observe(input logic [1:0] k, input logic [7:0] d);
        ev_t got, exp;
        got.kind = k;
        got.data = d;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%0h expected none at %0t", k, d, $time);
        end else begin
            exp = exp_q.pop_front();
            check("event", got, exp);
        end
    endtask

    initial begin
        logic prev_wck;
        logic prev_wrst;
        int   low_cnt;
        prev_wck  = 1'b0;
        prev_wrst = 1'b1;
        low_cnt   = 0;
        forever begin
            @(negedge in_clk);
            if (!in_nrst) begin
                prev_wck  = 1'b0;
                prev_wrst = 1'b1;
                low_cnt   = 0;
                continue;
            end
            if (frame_err)  observe(EV_ERR, 8'h00);
            if (frame_done) observe(EV_DONE, 8'h00);
            if (prev_wrst && !al_wrst_n) observe(EV_RST, 8'h00);
            if (!al_wrst_n) begin
                low_cnt++;
            end else if (!prev_wrst) begin
                check("wrst_low_cycles", low_cnt, 2 * WR);
                low_cnt = 0;
            end
            if (!prev_wck && al_wck && !al_we_n) observe(EV_W, al_data);
            prev_wck  = al_wck;
            prev_wrst = al_wrst_n;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] d, input logic s);
        int budget;
        budget = 64;
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        while (!in_ready && budget > 0) begin
            @(negedge in_clk);
            budget--;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(d, s);
        end
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge in_clk);
            budget--;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_wck", al_wck, 1'b0);
        check("rst_we_n", al_we_n, 1'b1);
        check("rst_wrst_n", al_wrst_n, 1'b1);
        check("rst_data", al_data, 8'h00);
        check("rst_done", frame_done, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_ready", in_ready, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        repeat (3) @(negedge in_clk);
        check_reset_outputs();
        in_nrst = 1'b1;

        // Idle after release: al_wck toggles from the first edge, ready follows it.
        for (int k = 1; k <= 8; k++) begin
            @(negedge in_clk);
            check("idle_wck", al_wck, k[0]);
            check("idle_ready", in_ready, k[0]);
            check("idle_we_n", al_we_n, 1'b1);
            check("idle_wrst_n", al_wrst_n, 1'b1);
        end

        // Full frame, back-to-back.
        for (int i = 1; i <= FB; i++) send(8'(i * 8'h11), i == 1);
        drain();

        // Non-sof bytes in IDLE are dropped.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        repeat (10) @(negedge in_clk);
        drain();

        // Short frame interrupted by a new sof, then complete the new frame.
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h09, 1'b1);
        for (int i = 0; i < FB - 1; i++) send(8'(8'h0A + i), 1'b0);
        drain();

        // Frame with 3-slot gaps between bytes.
        send(8'h41, 1'b1);
        for (int i = 2; i <= FB; i++) begin
            repeat (6) @(negedge in_clk);
            send(8'(8'h40 + i), 1'b0);
        end
        drain();

        // Reset after the third write abandons the frame silently.
        send(8'h31, 1'b1);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        drain();
        @(posedge in_clk);
        #3;
        in_nrst = 1'b0;
        #1;
        check_reset_outputs();
        m_in_frame = 0;
        m_cnt = 0;
        repeat (2) @(negedge in_clk);
        in_nrst = 1'b1;
        send(8'h34, 1'b0);
        repeat (20) @(negedge in_clk);
        drain();

        // Randomized traffic: random data, occasional sof, random gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge in_clk);
            send(8'($urandom), $urandom_range(0, 6) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/al422_frame_writer.md
AL422_FRAME_WRITER -- requirements
Module: al422_frame_writer

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 6144, giving the bytes per frame (64x32 pixels, 3 bytes R,G,B per pixel).
REQ-002 The block SHALL have parameter WRST_CYCLES, default 4, giving the number of al_wck periods during which al_wrst_n is held low.
REQ-003 in_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 in_nrst  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  source byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_sof  input  1  qualified by in_valid; marks the first byte of a frame.
REQ-008 in_ready  output  1  byte accepted on a cycle where in_valid & in_ready are both high.
REQ-009 al_wck  output  1  AL422 write clock, registered.
REQ-010 al_we_n  output  1  AL422 write enable, active-low, registered.
REQ-011 al_wrst_n  output  1  AL422 write-pointer reset, active-low, registered.
REQ-012 al_data  output  8  AL422 DI bus, registered.
REQ-013 frame_done  output  1  one-cycle pulse when FRAME_BYTES bytes have been written.
REQ-014 frame_err  output  1  one-cycle pulse when a new frame starts before the current frame completes.

Function
REQ-015 After reset, al_wck SHALL toggle every in_clk cycle in all states, giving a period of 2 in_clk; a "slot" is one low phase followed by one high phase.
REQ-016 in_ready SHALL be combinational: it is 1 only when the state is IDLE or WRITE and al_wck == 1.
REQ-017 States SHALL be IDLE, RST, WRITE, and PAD (PAD exists only when AL422_WR_PAD_EN is defined).
REQ-018 IDLE: accepted bytes with in_sof = 0 SHALL be dropped; an accepted byte with in_sof = 1 SHALL be stored in a hold register, and the state SHALL go to RST.
REQ-019 RST: al_wrst_n = 0 and al_we_n = 1 for exactly WRST_CYCLES slots, starting with the slot following acceptance; the byte counter SHALL be cleared to 0.
REQ-020 The first slot after RST SHALL write the hold byte: al_data = hold, al_we_n = 0 for the whole slot, and al_wrst_n = 1. The state SHALL then be WRITE, with counter = 1.
REQ-021 WRITE: a byte accepted in the high phase SHALL appear on al_data with al_we_n = 0 for the whole next slot, so the AL422 samples it on that slot's al_wck rising edge; each write SHALL increment the counter.
REQ-022 WRITE with no byte accepted: the next slot SHALL have al_we_n = 1 and al_data held (idle slot, no count).
REQ-023 When the counter reaches FRAME_BYTES, frame_done SHALL pulse for one cycle, coincident with the last write slot's low phase, and the state SHALL go to IDLE; further bytes are treated per REQ-018.
REQ-024 WRITE, accepted in_sof = 1 with counter < FRAME_BYTES: frame_err SHALL pulse, and the byte SHALL be stored in the hold register; handling then follows the Configuration section.
REQ-025 If FRAME_BYTES writes complete and an in_sof arrives in the same slot, frame_done takes priority; the sof byte SHALL be processed in IDLE on the next acceptance only.
REQ-026 The counter SHALL be wide enough for FRAME_BYTES and SHALL never wrap past it.

Reset
REQ-027 in_nrst low SHALL force, asynchronously: state IDLE, counter 0, hold register 0x00, al_wck 0, al_we_n 1, al_wrst_n 1, al_data 0x00, frame_done 0, frame_err 0, and therefore in_ready 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a frame_done or frame_err pulse; the next frame requires a new in_sof.

Configuration
REQ-029 The macro AL422_WR_PAD_EN SHALL select how a short frame is handled.
REQ-030 With AL422_WR_PAD_EN defined: after REQ-024, the state SHALL go to PAD, with in_ready = 0, writing 0x00 each slot (al_we_n = 0) until counter = FRAME_BYTES; there SHALL be no frame_done pulse. The state SHALL then go to RST and the hold byte is written per REQ-020.
REQ-031 With AL422_WR_PAD_EN undefined: after REQ-024, the state SHALL go directly to RST, and the short frame stays truncated in the FIFO.

Verification (FRAME_BYTES = 6, WRST_CYCLES = 2)
REQ-032 Reset release, then idle -> al_wck toggles starting in the first cycle; al_we_n = 1, al_wrst_n = 1, and in_ready is high on every al_wck = 1 cycle.
REQ-033 Stimulus: bytes 0x11 (sof), 0x22..0x66 back-to-back -> al_wrst_n low for 4 in_clk; then 6 write slots with data 0x11..0x66 and al_we_n low; frame_done pulses once; no frame_err.
REQ-034 Non-sof bytes 0xAA, 0xBB in IDLE -> no write slots and no al_wrst_n pulse.
REQ-035 sof 0x01, 0x02, then sof 0x09 -> frame_err pulses. With PAD_EN: 4 writes of 0x00, then WRST, then 0x09 written. Without PAD_EN: WRST immediately, then 0x09 written.
REQ-036 in_valid gaps of 3 slots inside a frame -> those slots have al_we_n = 1; the count and the data order are intact.
REQ-037 in_nrst pulsed low after the 3rd write -> all outputs return to the REQ-027 values immediately, and there is no frame_done pulse.
